// File: rtl/d_using_jk_flip_flop_pkg.sv
// Shared JK mode encoding and next-state helper for the D-from-JK register.
`timescale 1ns/1ps
package d_using_jk_flip_flop_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    function automatic logic jk_next(input jk_mode_e mode, input logic q_cur);
        logic q_nxt;
        q_nxt = q_cur;
        case (mode)
            JK_HOLD:   q_nxt = q_cur;
            JK_CLEAR:  q_nxt = 1'b0;
            JK_SET:    q_nxt = 1'b1;
            JK_TOGGLE: q_nxt = ~q_cur;
            default:   q_nxt = q_cur;
        endcase
        return q_nxt;
    endfunction

endpackage

// File: rtl/d_using_jk_flip_flop_if.sv
// Bundles the data/reset side of a d_using_jk_flip_flop instance.
`timescale 1ns/1ps
interface d_using_jk_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output reset, output d, input  q);
    modport slave  (input  reset, input  d, output q);
endinterface

// File: rtl/d_using_jk_flip_flop_jk_flip_flop.sv
// Single JK flip-flop cell with asynchronous active-high clear.
`timescale 1ns/1ps
module jk_flip_flop
    import d_using_jk_flip_flop_pkg::*;
(
    output logic q,
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k
);
    jk_mode_e w_mode;
    logic     r_q;

    assign w_mode = jk_mode_e'({j, k});

    // Reset wins over every J/K combination, including toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(w_mode, r_q);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/d_using_jk_flip_flop.sv
// WIDTH-bit D register built from JK cells driven with J=d, K=~d.
`timescale 1ns/1ps
module d_using_jk_flip_flop #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_j;
            logic w_k;

            // J and K are always complementary, so hold and toggle never occur here.
            assign w_j = d[gi];
            assign w_k = ~d[gi];

            jk_flip_flop u_jk (
                .q     (q[gi]),
                .clk   (clk),
                .reset (reset),
                .j     (w_j),
                .k     (w_k)
            );
        end
    endgenerate
endmodule

// File: tb/tb_d_using_jk_flip_flop.sv
// Directed bench: 1-bit and 4-bit D registers plus a standalone JK cell.
`timescale 1ns/1ps
module tb_d_using_jk_flip_flop;
    import d_using_jk_flip_flop_pkg::*;

    logic clk;
    int   n_tests;
    int   n_fail;

    logic jk_reset;
    logic jk_j;
    logic jk_k;
    logic jk_q;

    d_using_jk_flip_flop_if #(.WIDTH(1)) if1 ();
    d_using_jk_flip_flop_if #(.WIDTH(4)) if4 ();

    d_using_jk_flip_flop #(.WIDTH(1)) u_dut1 (
        .q     (if1.q),
        .clk   (clk),
        .reset (if1.reset),
        .d     (if1.d)
    );

    d_using_jk_flip_flop #(.WIDTH(4)) u_dut4 (
        .q     (if4.q),
        .clk   (clk),
        .reset (if4.reset),
        .d     (if4.d)
    );

    jk_flip_flop u_jk (
        .q     (jk_q),
        .clk   (clk),
        .reset (jk_reset),
        .j     (jk_j),
        .k     (jk_k)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic at_t(input longint t);
        #(t - $time);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input jk_mode_e m);
        {jk_j, jk_k} = m;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        if1.reset   = 1'b0;
        if4.reset   = 1'b1;
        if4.d       = 4'b1111;
        jk_reset    = 1'b1;
        set_mode(JK_TOGGLE);

        at_t(1);
        check("w4_reset_state", if4.q, 4'b0000);
        check("jk_reset_state", {3'b000, jk_q}, 4'b0000);

        // Basic capture of 0 and 1, one-edge latency
        at_t(10); if1.d = 1'b0;
        at_t(16); check("d0_edge15", {3'b000, if1.q}, 4'b0000);
        at_t(26); check("d0_hold_edge25", {3'b000, if1.q}, 4'b0000);
        at_t(30); if1.d = 1'b1;
        at_t(31); check("d1_before_edge", {3'b000, if1.q}, 4'b0000);
        at_t(36); check("d1_edge35", {3'b000, if1.q}, 4'b0001);
        at_t(46); check("d1_hold_edge45", {3'b000, if1.q}, 4'b0001);

        // Asynchronous reset with d=1 held, then release mid-cycle
        at_t(48); if1.reset = 1'b1;
        at_t(49); check("rst_immediate", {3'b000, if1.q}, 4'b0000);
        at_t(56); check("rst_edge55", {3'b000, if1.q}, 4'b0000);
        at_t(66); check("rst_edge65", {3'b000, if1.q}, 4'b0000);
        at_t(68); if1.reset = 1'b0;
        at_t(69); check("rst_release_noglitch", {3'b000, if1.q}, 4'b0000);
        at_t(76); check("post_rst_edge75", {3'b000, if1.q}, 4'b0001);

        // Pulse on d entirely between edges; final value wins
        at_t(78); if1.d = 1'b0;
        at_t(80); if1.d = 1'b1;
        at_t(82); if1.d = 1'b0;
        at_t(86); check("pulse_final0", {3'b000, if1.q}, 4'b0000);
        at_t(88); if1.d = 1'b1;
        at_t(89); check("mid_change_ignored", {3'b000, if1.q}, 4'b0000);
        at_t(96); check("mid_change_edge95", {3'b000, if1.q}, 4'b0001);

        // 4-bit instance, independent bits
        at_t(98);  if4.reset = 1'b0; if4.d = 4'b1010;
        at_t(101); check("w4_before_edge", if4.q, 4'b0000);
        at_t(106); check("w4_1010", if4.q, 4'b1010);
        if4.d = 4'b0101;
        at_t(109); check("w4_hold_between", if4.q, 4'b1010);
        at_t(116); check("w4_0101", if4.q, 4'b0101);

        // Standalone JK cell: 00,01,10,11 then repeated toggles
        at_t(118); jk_reset = 1'b0; set_mode(JK_HOLD);
        at_t(126); check("jk_hold", {3'b000, jk_q}, 4'b0000);
        set_mode(JK_CLEAR);
        at_t(136); check("jk_clear", {3'b000, jk_q}, 4'b0000);
        set_mode(JK_SET);
        at_t(146); check("jk_set", {3'b000, jk_q}, 4'b0001);
        set_mode(JK_HOLD);
        at_t(156); check("jk_hold_at1", {3'b000, jk_q}, 4'b0001);
        set_mode(JK_TOGGLE);
        at_t(166); check("jk_toggle_a", {3'b000, jk_q}, 4'b0000);
        at_t(176); check("jk_toggle_b", {3'b000, jk_q}, 4'b0001);
        at_t(186); check("jk_toggle_c", {3'b000, jk_q}, 4'b0000);
        at_t(196); check("jk_toggle_d", {3'b000, jk_q}, 4'b0001);

        // Reset overrides toggle
        at_t(198); jk_reset = 1'b1;
        at_t(199); check("jk_rst_immediate", {3'b000, jk_q}, 4'b0000);
        at_t(206); check("jk_rst_over_toggle", {3'b000, jk_q}, 4'b0000);

        at_t(210);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/d_using_jk_flip_flop.md
D_USING_JK_FLIP_FLOP -- requirements
Module: d_using_jk_flip_flop

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent D bits (one JK cell per bit).
REQ-002 Port order (positional instantiation supported): q, clk, reset, d.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears q.
REQ-005 d  input  WIDTH  data to capture.
REQ-006 q  output  WIDTH  registered state; driven directly from flop, no combinational path from d.

Function
REQ-007 Per bit, the block SHALL derive J = d and K = ~d and feed them to a JK flip-flop cell.
REQ-008 JK cell SHALL implement on rising clk: J=0,K=0 hold; J=0,K=1 q<=0; J=1,K=0 q<=1; J=1,K=1 q<=~q.
REQ-009 Net behaviour SHALL equal a D flip-flop: q(n+1) = d sampled at rising edge n; latency exactly one edge.
REQ-010 Toggle and hold cases SHALL be unreachable from the d input but SHALL still be implemented in the JK cell.
REQ-011 d changes between edges SHALL NOT affect q until the next rising edge.
REQ-012 d changing coincident with the clock edge is outside the timing contract; simulation uses the pre-edge value.
REQ-013 With reset never asserted, q SHALL be unknown until the first rising edge on which d is known; no implicit power-up value is required.
REQ-014 Each bit of a WIDTH>1 instance SHALL behave independently and identically.

Reset
REQ-015 reset=1 SHALL force q to all zeros immediately, without waiting for clk.
REQ-016 While reset=1, rising clk edges SHALL be ignored and q SHALL remain 0.
REQ-017 After reset deasserts, the first rising edge SHALL load d normally; reset release mid-cycle SHALL produce no glitch on q.
REQ-018 Reset asserted mid-operation SHALL override any pending capture; reset has priority over J/K.

Structure
REQ-019 Sub-module jk_flip_flop (ports: q, clk, reset, j, k; 1-bit) SHALL hold all state; the top SHALL generate WIDTH instances and the J/K derivation logic only.
REQ-020 A shared package SHALL define the JK mode encoding (HOLD=00, CLEAR=01, SET=10, TOGGLE=11) used by jk_flip_flop and its bench.
REQ-021 No other state, latches or clock gating SHALL exist in the block.

Verification (clk period 10 ns, first rising edge at 5 ns)
REQ-022 reset=0 from t=0, d=0 applied at 10 ns -> q=0 after edge at 15 ns; d held 0 -> q stays 0 after 25 ns.
REQ-023 d=1 applied at 30 ns -> q=1 after edge at 35 ns; d held 1 -> q stays 1 after 45 ns.
REQ-024 q=1, assert reset between edges -> q=0 immediately; clk edges with d=1 during reset -> q stays 0; release reset -> next edge gives q=1.
REQ-025 d pulses 0->1->0 entirely between two edges -> q unchanged at next edge relative to final d (q=0).
REQ-026 jk_flip_flop standalone: from q=0 apply each of 00,01,10,11 across successive edges -> q = 0,0,1,0; repeated 11 -> q alternates 1,0,1.
REQ-027 WIDTH=4, d=4'b1010 then 4'b0101 on successive edges -> q=1010 then 0101, one-edge latency per bit.
